// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CSUM,
    RELEASE,
    RUN,
    ERROR
  } state_t;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned WORD_BYTES        = 4;
  localparam int unsigned ADDR_BYTES        = 4;
  localparam int unsigned LEN_BYTES         = 2;
  localparam int unsigned DEFAULT_MAX_WORDS = 1024;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  // Byte source / memory sink side.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/prog_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid pulses the
// cycle after the fourth byte of a word is taken.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_c,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [1:0]               idx;
  logic [WORD_W-BYTE_W-1:0] partial;

  // Next accepted byte completes the current word.
  assign last_c = (idx == 2'(WORD_BYTES - 1));

  // Byte index, partial shift register and completed-word register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      partial    <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx     <= '0;
        partial <= '0;
      end else if (byte_valid) begin
        if (last_c) begin
          word_data  <= {byte_data, partial};
          word_valid <= 1'b1;
          idx        <= '0;
        end else begin
          partial <= {byte_data, partial[WORD_W-BYTE_W-1:BYTE_W]};
          idx     <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receives a framed program over a byte stream, writes it into instruction
// memory, verifies an XOR checksum and releases the processor.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.slave      bus,
  input  logic              load_req,
  output logic              hlt,
  output logic              preset,
  output logic [WORD_W-1:0] start_addr,
  output logic              load_done,
  output logic              load_err
);

  state_t            state;
  logic [1:0]        hdr_cnt;
  logic [WORD_W-1:0] base;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [BYTE_W-1:0] csum;
  logic [WORD_W-1:0] wr_addr;

  logic              ready;
  logic              accept;
  logic              restart;
  logic              pack_valid;
  logic              pack_last;
  logic              pack_we;
  logic [WORD_W-1:0] pack_word;
  logic [WORD_W-1:0] base_nxt;
  logic [15:0]       len_nxt;
  logic              len_bad;

  // Handshake qualifiers and little-endian header accumulation.
  assign ready      = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CSUM);
  assign accept     = bus.rx_valid && ready;
  assign restart    = load_req && (state != IDLE);
  assign pack_valid = accept && (state == DATA) && !load_req;
  assign base_nxt   = {bus.rx_data, base[WORD_W-1:BYTE_W]};
  assign len_nxt    = {bus.rx_data, len[15:BYTE_W]};
  assign len_bad    = (len_nxt == 16'd0) || (32'(len_nxt) > MAX_WORDS);

  assign bus.rx_ready   = ready;
  assign bus.imem_we    = pack_we;
  assign bus.imem_addr  = wr_addr;
  assign bus.imem_wdata = pack_word;

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .byte_valid (pack_valid),
    .byte_data  (bus.rx_data),
    .last_c     (pack_last),
    .word_valid (pack_we),
    .word_data  (pack_word)
  );

  // Frame FSM with registered status outputs; load_req wins over any byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hdr_cnt    <= '0;
      base       <= '0;
      len        <= '0;
      word_cnt   <= '0;
      csum       <= '0;
      wr_addr    <= '0;
      hlt        <= 1'b1;
      preset     <= 1'b0;
      start_addr <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      preset <= 1'b0;
      if (restart) begin
        state     <= ADDR;
        hdr_cnt   <= '0;
        word_cnt  <= '0;
        csum      <= '0;
        hlt       <= 1'b1;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ADDR;
          ADDR: if (accept) begin
            base <= base_nxt;
            csum <= csum ^ bus.rx_data;
            if (hdr_cnt == 2'(ADDR_BYTES - 1)) begin
              hdr_cnt <= '0;
              if (base_nxt[1:0] != 2'b00) begin
                state    <= ERROR;
                load_err <= 1'b1;
              end else begin
                state <= LEN;
              end
            end else begin
              hdr_cnt <= hdr_cnt + 2'd1;
            end
          end
          LEN: if (accept) begin
            len  <= len_nxt;
            csum <= csum ^ bus.rx_data;
            if (hdr_cnt == 2'(LEN_BYTES - 1)) begin
              hdr_cnt  <= '0;
              word_cnt <= '0;
              if (len_bad) begin
                state    <= ERROR;
                load_err <= 1'b1;
              end else begin
                state <= DATA;
              end
            end else begin
              hdr_cnt <= hdr_cnt + 2'd1;
            end
          end
          DATA: if (accept) begin
            csum <= csum ^ bus.rx_data;
            if (pack_last) begin
              wr_addr  <= base + 32'({word_cnt, 2'b00});
              word_cnt <= word_cnt + 16'd1;
              if (word_cnt == len - 16'd1) state <= CSUM;
            end
          end
          CSUM: if (accept) begin
            if (bus.rx_data == csum) begin
              state      <= RELEASE;
              preset     <= 1'b1;
              start_addr <= base;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
          RELEASE: begin
            state     <= RUN;
            hlt       <= 1'b0;
            load_done <= 1'b1;
          end
          RUN:     state <= RUN;
          ERROR:   state <= ERROR;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
